mult_accum: RTL
===============

Name: mult_accum

Overview:
- Downstream consumer of the pipelined 4x4 multiplier (mult_fast).
- Tracks operand validity alongside the multiplier pipeline and accumulates the 8-bit products into frames (dot products) delimited by a last flag.
- Presents each completed frame sum and term count on a valid/ready output port.
- Instantiates mult_fast internally; mult_fast itself is unchanged.

Parameters:
- ACC_W, 16, accumulator and result width (min 8).
- CNT_W, 9, term-counter width.
- LAT, 2, mult_fast latency in clk edges from operand sampling to P update; sizes the tag delay line.

Ports:
- clk  input  1  system clock, posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  A/B carry a term this cycle.
- in_last  input  1  term is the final one of its frame; ignored unless in_valid.
- A  input  4  multiplicand, fed to mult_fast.
- B  input  4  multiplier, fed to mult_fast.
- out_valid  output  1  result registers hold an unaccepted frame result.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- sum_out  output  ACC_W  frame sum.
- cnt_out  output  CNT_W  number of terms in the frame.
- ovf_out  output  1  frame saturated (sum or count).
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All registers below are cleared on a rising clk edge with rst=1.
- Reset values: out_valid=0, sum_out=0, cnt_out=0, ovf_out=0, overrun=0, tag line=0, state=IDLE.
- Tag line: {in_valid, in_last} are sampled on the same edge as A/B, then delayed LAT further edges, so tag_v/tag_l align with mult_fast P.
- Because mult_fast has no reset, rst only clears tags. In-flight products at reset are discarded.
- FSM, evaluated on each edge where tag_v=1:
  - IDLE: acc_nxt=P, cnt_nxt=1. If tag_l, complete the frame and stay IDLE; else go to ACC.
  - ACC: acc_nxt=acc+P, cnt_nxt=cnt+1. If tag_l, complete the frame and go to IDLE; else stay in ACC.
  - tag_v=0: acc, cnt and state hold. Gaps inside a frame are legal.
- Width rules:
  - P is zero-extended to ACC_W.
  - If acc+P exceeds 2^ACC_W-1, acc saturates at all-ones and the frame ovf bit is set.
  - cnt saturates at 2^CNT_W-1 and also sets ovf.
  - ovf clears when a new frame starts (the IDLE branch).
- Completion: on the same edge, sum_out<=acc_nxt, cnt_out<=cnt_nxt, ovf_out<=ovf_nxt, out_valid<=1.
- Latency: a single-term frame presented before edge k (sampled at edge k) gives out_valid=1 after edge k+LAT+1, i.e. k+3.
- Handshake:
  - out_valid drops on the edge where out_valid && out_ready, unless a completion occurs on that same edge.
  - sum_out, cnt_out and ovf_out are stable while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Completion while out_valid=1 and out_ready=1: the new result replaces the old one, out_valid stays 1, no overrun.
  - Completion while out_valid=1 and out_ready=0: the new result is dropped, the held result is kept, and overrun<=1.
  - overrun is sticky until rst.
  - Accumulation is never stalled; there is no input backpressure.
- Reset mid-frame: the partial frame is lost, and the first tagged term after reset opens a new frame.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_ACC=1'b1;
  - the mult_fast latency constant MULT_LAT=2, used as the LAT default.
- One sub-module is natural: mult_tag_delay, a LAT-deep, 2-bit-wide shift register with synchronous reset.
- mult_fast is instantiated as-is.

Test Plan:
- Single-term frame A=3, B=5, in_last=1, out_ready=1 -> out_valid high exactly 3 edges after sampling; sum_out=15, cnt_out=1, ovf_out=0; out_valid drops the next edge.
- Frame (2,3),(4,4),(15,15) with last on the third term and back-to-back valid -> sum_out=247, cnt_out=3. Repeat with a 2-cycle in_valid=0 gap mid-frame -> same result.
- Two back-to-back single-term frames (1,1) then (2,2), out_ready=0 -> first result held (sum_out=1); overrun=1; sum_out unchanged. Raise out_ready -> out_valid drops, overrun stays 1.
- Same as the previous scenario but with out_ready=1 throughout -> results 1 then 4 on consecutive cycles; overrun=0.
- ACC_W=8, frame of two (15,15) terms -> sum_out=255, ovf_out=1, cnt_out=2. Next frame (1,1) -> sum_out=1, ovf_out=0.
- Assert rst for 1 cycle after two terms of an open frame, then a single-term frame (2,7) -> sum_out=14, cnt_out=1, no stale contribution. All outputs 0 during and after the reset edge.

Source files
------------

// File: rtl/mult_accum_pkg.sv
// Shared types and constants for the multiplier-accumulator slice.
package mult_accum_pkg;

  // Edges from operand sampling in mult_fast to the matching P update.
  localparam int MULT_LAT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_accum_tag_delay.sv
// DEPTH-stage, 2-bit shift register with synchronous reset for the {valid,last} tag.
module mult_tag_delay
  import mult_accum_pkg::*;
#(
  parameter int DEPTH = MULT_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= 2'b00;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/mult_fast.sv
// Pipelined 4x4 unsigned multiplier: operands sampled on edge k, P updated on edge k+2.
module mult_fast (
  input  logic       clk,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] P
);

  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [5:0] pp_lo;
  logic [5:0] pp_hi;

  // Split B into two 2-bit digits so each stage stays shallow.
  always_ff @(posedge clk) begin
    a_q   <= A;
    b_q   <= B;
    pp_lo <= {2'b00, a_q} * {4'b0000, b_q[1:0]};
    pp_hi <= {2'b00, a_q} * {4'b0000, b_q[3:2]};
    P     <= {2'b00, pp_lo} + {pp_hi, 2'b00};
  end

endmodule

// File: rtl/mult_accum.sv
// Accumulates mult_fast products into last-delimited frames and presents each
// frame sum and term count on a valid/ready port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no frame open; next tagged product starts a new frame
//   ST_ACC  | frame open; tagged products add into acc until last
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 9,
  parameter int LAT   = MULT_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [3:0]       A,
  input  logic [3:0]       B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic [CNT_W-1:0] cnt_out,
  output logic             ovf_out,
  output logic             overrun
);

  logic [7:0]       p;
  logic [1:0]       tag_in_q;
  logic [1:0]       tag_q;
  logic             tag_v;
  logic             tag_l;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic             done;
  logic [ACC_W:0]   sum_wide;

  mult_fast u_mult (
    .clk (clk),
    .A   (A),
    .B   (B),
    .P   (p)
  );

  // The tag is sampled alongside A/B, then trails it by LAT more edges to meet P.
  always_ff @(posedge clk) begin
    if (rst) tag_in_q <= 2'b00;
    else     tag_in_q <= {in_valid, in_valid & in_last};
  end

  mult_tag_delay #(.DEPTH(LAT)) u_tag (
    .clk (clk),
    .rst (rst),
    .d   (tag_in_q),
    .q   (tag_q)
  );

  assign tag_v = tag_q[1];
  assign tag_l = tag_q[0];

  assign sum_wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, p};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    done      = 1'b0;
    if (tag_v) begin
      case (state)
        ST_IDLE: begin
          acc_nxt = {{(ACC_W-8){1'b0}}, p};
          cnt_nxt = CNT_W'(1);
          ovf_nxt = 1'b0;
          if (tag_l) done = 1'b1;
          else       state_nxt = ST_ACC;
        end
        ST_ACC: begin
          if (sum_wide[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum_wide[ACC_W-1:0];
          end
          if (&cnt) begin
            ovf_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
          if (tag_l) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // A completion may replace a result being accepted this edge; otherwise a
  // held, unaccepted result wins and the new one is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_out   <= '0;
      cnt_out   <= '0;
      ovf_out   <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        sum_out   <= acc_nxt;
        cnt_out   <= cnt_nxt;
        ovf_out   <= ovf_nxt;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
